alu_nibble_seq: RTL and testbench

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

---
 rtl/alu_pkg.sv | 94 +++++++++
 rtl/alu_nib_flags.sv | 71 +++++++
 rtl/alu_nibble_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_nibble_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the nibble-serial ALU sequencer.
// Holds the operation encoding, the sequencer state encoding, the
// {R,S,V} control triples understood by the external 4-bit alu_core,
// and small decode helpers used by the sequencer.
package alu_pkg;

  // Operation encoding as presented on the op input.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_SBC = 3'b011,
    OP_AND = 3'b100,
    OP_XOR = 3'b101,
    OP_OR  = 3'b110,
    OP_CP  = 3'b111
  } alu_op_e;

  // Sequencer states: one low-nibble pass, one high-nibble pass, one
  // completion cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Core control triples, packed as {R, S, V}.
  localparam logic [2:0] CTL_ARITH = 3'b000;
  localparam logic [2:0] CTL_XOR   = 3'b100;
  localparam logic [2:0] CTL_AND   = 3'b010;
  localparam logic [2:0] CTL_OR    = 3'b111;

  // Fixed carry-in the core expects for each logic function.
  localparam logic CIN_XOR = 1'b0;
  localparam logic CIN_AND = 1'b1;
  localparam logic CIN_OR  = 1'b0;

  // Subtract-class ops feed the core an inverted second operand.
  function automatic logic op_is_sub(alu_op_e op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

  // Logic-class ops do not use the carry chain.
  function automatic logic op_is_logic(alu_op_e op);
    return (op == OP_AND) || (op == OP_XOR) || (op == OP_OR);
  endfunction

  // Control triple for the core, identical in both passes.
  function automatic logic [2:0] op_ctl(alu_op_e op);
    logic [2:0] ctl;
    ctl = CTL_ARITH;
    case (op)
      OP_AND:  ctl = CTL_AND;
      OP_XOR:  ctl = CTL_XOR;
      OP_OR:   ctl = CTL_OR;
      default: ctl = CTL_ARITH;
    endcase
    return ctl;
  endfunction

  // Carry-in for the low-nibble pass.
  function automatic logic op_cin_lo(alu_op_e op, logic cf);
    logic cin;
    cin = 1'b0;
    case (op)
      OP_ADD:  cin = 1'b0;
      OP_ADC:  cin = cf;
      OP_SUB:  cin = 1'b1;
      OP_SBC:  cin = ~cf;
      OP_CP:   cin = 1'b1;
      OP_AND:  cin = CIN_AND;
      OP_XOR:  cin = CIN_XOR;
      OP_OR:   cin = CIN_OR;
      default: cin = 1'b0;
    endcase
    return cin;
  endfunction

  // Carry-in for the high-nibble pass: arithmetic chains the low carry,
  // logic functions keep their fixed control carry.
  function automatic logic op_cin_hi(alu_op_e op, logic lo_cy);
    logic cin;
    cin = lo_cy;
    case (op)
      OP_AND:  cin = CIN_AND;
      OP_XOR:  cin = CIN_XOR;
      OP_OR:   cin = CIN_OR;
      default: cin = lo_cy;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/alu_nib_flags.sv
// alu_nib_flags -- combinational flag derivation for the sequencer.
// Takes the assembled 8-bit value plus the low/high nibble carries and
// the high-nibble overflow from the core and forms cf/hf/vf/zf/sf.
// Build option ALU_SEQ_PARITY_EN: when defined, logic ops report even
// parity on vf (Z80 P/V); otherwise vf is 0 for logic ops and no parity
// tree is built.
module alu_nib_flags
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] value,
  input  logic       lo_cy,
  input  logic       hi_cy,
  input  logic       hi_vf,
  output logic       cf,
  output logic       hf,
  output logic       vf,
  output logic       zf,
  output logic       sf
);

  alu_op_e op_e;
  logic    logic_vf;

  assign op_e = alu_op_e'(op);

`ifdef ALU_SEQ_PARITY_EN
  // Even parity of the result: 1 when the number of set bits is even.
  assign logic_vf = ~^value;
`else
  assign logic_vf = 1'b0;
`endif

  // Flag selection per op class; subtract-class carries are borrows,
  // so the core carries are inverted.
  always_comb begin
    cf = 1'b0;
    hf = 1'b0;
    vf = 1'b0;
    zf = (value == 8'h00);
    sf = value[7];
    case (op_e)
      OP_ADD, OP_ADC: begin
        cf = hi_cy;
        hf = lo_cy;
        vf = hi_vf;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        cf = ~hi_cy;
        hf = ~lo_cy;
        vf = hi_vf;
      end
      OP_AND: begin
        cf = 1'b0;
        hf = 1'b1;
        vf = logic_vf;
      end
      OP_XOR, OP_OR: begin
        cf = 1'b0;
        hf = 1'b0;
        vf = logic_vf;
      end
      default: begin
        cf = 1'b0;
        hf = 1'b0;
        vf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq -- runs an 8-bit ALU operation as two passes through an
// external 4-bit alu_core (low nibble, then high nibble), then presents a
// registered result and flags with a one-cycle done pulse.
// Build option ALU_SEQ_PARITY_EN selects parity on vf for logic ops
// (see alu_nib_flags).
//
// Handshake: start is accepted only on a rising edge where the sequencer
// is IDLE (busy=0 and done=0) and nreset=1; operands are captured on that
// edge. busy is high for the two core passes, done pulses for exactly one
// cycle three cycles after acceptance, and result/flags hold until the
// next done. Asserting start at any other time has no effect.
module alu_nibble_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cf_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       cf,
  output logic       hf,
  output logic       vf,
  output logic       zf,
  output logic       sf,
  output logic [3:0] core_op1,
  output logic [3:0] core_op2,
  output logic       core_cy_in,
  output logic       core_R,
  output logic       core_S,
  output logic       core_V,
  input  logic [3:0] core_result,
  input  logic       core_cy_out,
  input  logic       core_vf_out,
  output logic [1:0] state_dbg
);

  seq_state_e state;
  seq_state_e state_next;
  logic       accept;

  alu_op_e    op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       cf_q;

  logic [3:0] lo_res_q;
  logic       lo_cy_q;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [2:0] ctl;

  logic [7:0] value;
  logic       f_cf;
  logic       f_hf;
  logic       f_vf;
  logic       f_zf;
  logic       f_sf;

  assign accept    = (state == ST_IDLE) && start;
  assign state_dbg = state;
  assign busy      = (state == ST_LO) || (state == ST_HI);
  assign done      = (state == ST_DONE);

  // State register; reset from any state returns to IDLE (abort).
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: fixed four-cycle walk once started.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LO;
      ST_LO:   state_next = ST_HI;
      ST_HI:   state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture on acceptance; held until the next acceptance.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      op_q <= OP_ADD;
      a_q  <= 8'h00;
      b_q  <= 8'h00;
      cf_q <= 1'b0;
    end else if (accept) begin
      op_q <= alu_op_e'(op);
      a_q  <= a;
      b_q  <= b;
      cf_q <= cf_in;
    end
  end

  // Keep the low-nibble pass result and carry for the high pass.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      lo_res_q <= 4'h0;
      lo_cy_q  <= 1'b0;
    end else if (state == ST_LO) begin
      lo_res_q <= core_result;
      lo_cy_q  <= core_cy_out;
    end
  end

  // Core drive: select the nibble for the current pass, invert the
  // second operand for subtract-class ops, and pick the carry-in.
  always_comb begin
    nib_a      = 4'h0;
    nib_b      = 4'h0;
    ctl        = op_ctl(op_q);
    core_op1   = 4'h0;
    core_op2   = 4'h0;
    core_cy_in = 1'b0;
    if (state == ST_LO) begin
      nib_a      = a_q[3:0];
      nib_b      = b_q[3:0];
      core_cy_in = op_cin_lo(op_q, cf_q);
    end else if (state == ST_HI) begin
      nib_a      = a_q[7:4];
      nib_b      = b_q[7:4];
      core_cy_in = op_cin_hi(op_q, lo_cy_q);
    end
    if (busy) begin
      core_op1 = nib_a;
      core_op2 = op_is_sub(op_q) ? ~nib_b : nib_b;
    end
  end

  assign core_R = ctl[2];
  assign core_S = ctl[1];
  assign core_V = ctl[0];

  // During HI the full 8-bit value is the live high nibble plus the
  // stored low nibble.
  assign value = {core_result, lo_res_q};

  alu_nib_flags u_flags (
    .op    (op_q),
    .value (value),
    .lo_cy (lo_cy_q),
    .hi_cy (core_cy_out),
    .hi_vf (core_vf_out),
    .cf    (f_cf),
    .hf    (f_hf),
    .vf    (f_vf),
    .zf    (f_zf),
    .sf    (f_sf)
  );

  // Result and flags load on the HI->DONE edge so they are valid in the
  // done cycle; CP updates flags only. An abort clears everything.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      result <= 8'h00;
      cf     <= 1'b0;
      hf     <= 1'b0;
      vf     <= 1'b0;
      zf     <= 1'b0;
      sf     <= 1'b0;
    end else if (state == ST_HI) begin
      if (op_q != OP_CP) begin
        result <= value;
      end
      cf <= f_cf;
      hf <= f_hf;
      vf <= f_vf;
      zf <= f_zf;
      sf <= f_sf;
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq -- directed bench for alu_nibble_seq with a
// behavioural 4-bit core attached to the core_* ports. Expected
// {result,cf,hf,vf,zf,sf} words are hand-computed and queued at issue;
// a monitor pops one on every done pulse. Honours ALU_SEQ_PARITY_EN.
module tb_alu_nibble_seq;

  localparam int W = 13;

`ifdef ALU_SEQ_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam logic [2:0] T_ADD = 3'b000;
  localparam logic [2:0] T_ADC = 3'b001;
  localparam logic [2:0] T_SUB = 3'b010;
  localparam logic [2:0] T_SBC = 3'b011;
  localparam logic [2:0] T_AND = 3'b100;
  localparam logic [2:0] T_XOR = 3'b101;
  localparam logic [2:0] T_OR  = 3'b110;
  localparam logic [2:0] T_CP  = 3'b111;

  logic       clk;
  logic       nreset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       cf_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cf, hf, vf, zf, sf;
  logic [3:0] core_op1, core_op2;
  logic       core_cy_in, core_R, core_S, core_V;
  logic [3:0] core_result;
  logic       core_cy_out, core_vf_out;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;
  int cyc;
  int period_start;
  bit period_chk;
  int last_done_cyc;
  int done_seen;

  alu_nibble_seq dut (
    .clk         (clk),
    .nreset      (nreset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .cf_in       (cf_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .cf          (cf),
    .hf          (hf),
    .vf          (vf),
    .zf          (zf),
    .sf          (sf),
    .core_op1    (core_op1),
    .core_op2    (core_op2),
    .core_cy_in  (core_cy_in),
    .core_R      (core_R),
    .core_S      (core_S),
    .core_V      (core_V),
    .core_result (core_result),
    .core_cy_out (core_cy_out),
    .core_vf_out (core_vf_out),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural alu_core ----------------
  logic [4:0] sum5;
  logic [3:0] sum3;
  always_comb begin
    sum5        = {1'b0, core_op1} + {1'b0, core_op2} + {4'b0, core_cy_in};
    sum3        = {1'b0, core_op1[2:0]} + {1'b0, core_op2[2:0]} + {3'b0, core_cy_in};
    core_result = 4'h0;
    core_cy_out = 1'b0;
    core_vf_out = 1'b0;
    case ({core_R, core_S, core_V})
      3'b000: begin
        core_result = sum5[3:0];
        core_cy_out = sum5[4];
        core_vf_out = sum5[4] ^ sum3[3];
      end
      3'b100: core_result = core_op1 ^ core_op2;
      3'b010: core_result = core_op1 & core_op2;
      3'b111: core_result = core_op1 | core_op2;
      default: core_result = 4'h0;
    endcase
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ex(input logic [7:0] r, input logic c,
                                      input logic h, input logic v,
                                      input logic z, input logic s);
    return {r, c, h, v, z, s};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      logic [W-1:0] got;
      logic [W-1:0] e;
      done_seen++;
      if (period_chk && last_done_cyc >= period_start)
        chk("done_period", 16'(cyc - last_done_cyc), 16'd4);
      last_done_cyc = cyc;
      got = {result, cf, hf, vf, zf, sf};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got res=%02h flags(c,h,v,z,s)=%05b with nothing expected",
                 result, got[4:0]);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL result_flags: got res=%02h c%0b h%0b v%0b z%0b s%0b expected res=%02h c%0b h%0b v%0b z%0b s%0b",
                   got[12:5], got[4], got[3], got[2], got[1], got[0],
                   e[12:5], e[4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  // Issue one operation, then scramble the inputs and check the
  // busy/done timing cycle by cycle.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic [W-1:0] e);
    wait_idle();
    op = o; a = x; b = y; cf_in = c; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    op = 3'($urandom_range(0, 7));
    cf_in = 1'($urandom_range(0, 1));
    chk("lo_busy", 16'({busy, done}), 16'b10);
    @(negedge clk);
    chk("hi_busy", 16'({busy, done}), 16'b10);
    @(negedge clk);
    chk("done_at_3", 16'({busy, done}), 16'b01);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]   va[3];
  logic [7:0]   vb[3];
  logic [W-1:0] ve[3];

  initial begin
    int issued;
    bit stop;
    n_cmp = 0; n_err = 0;
    period_chk = 0; period_start = 0; last_done_cyc = -1; done_seen = 0;
    nreset = 1'b0; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; cf_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy_done", 16'({busy, done}), 16'd0);
    chk("rst_result", 16'(result), 16'h00);
    chk("rst_flags", 16'({cf, hf, vf, zf, sf}), 16'd0);
    chk("rst_state", 16'(state_dbg), 16'd0);
    nreset = 1'b1;

    // Directed vectors
    issue(T_ADD, 8'h3A, 8'hC6, 1'b0, ex(8'h00, 1, 1, 0, 1, 0));
    issue(T_SBC, 8'h80, 8'h01, 1'b1, ex(8'h7E, 0, 1, 1, 0, 0));
    issue(T_CP,  8'h10, 8'h20, 1'b0, ex(8'h7E, 1, 0, 0, 0, 1));
    issue(T_AND, 8'h96, 8'h0F, 1'b0, ex(8'h06, 0, 1, PAR_EN, 0, 0));
    issue(T_XOR, 8'h5A, 8'h5A, 1'b1, ex(8'h00, 0, 0, PAR_EN, 1, 0));
    issue(T_OR,  8'h80, 8'h01, 1'b1, ex(8'h81, 0, 0, PAR_EN, 0, 1));
    issue(T_ADC, 8'hFF, 8'h00, 1'b1, ex(8'h00, 1, 1, 0, 1, 0));
    issue(T_SUB, 8'h05, 8'h05, 1'b1, ex(8'h00, 0, 0, 0, 1, 0));
    issue(T_ADD, 8'h7F, 8'h01, 1'b1, ex(8'h80, 0, 1, 1, 0, 1));

    // start held high: back-to-back issue, inputs scrambled while busy
    va = '{8'h11, 8'h0F, 8'h88};
    vb = '{8'h22, 8'h01, 8'h88};
    ve = '{ex(8'h33, 0, 0, 0, 0, 0), ex(8'h10, 0, 1, 0, 0, 0), ex(8'h10, 1, 1, 1, 0, 0)};
    wait_idle();
    period_start = cyc;
    period_chk = 1;
    issued = 0;
    stop = 0;
    for (int k = 0; k < 40 && !stop; k++) begin
      if (k != 0) @(negedge clk);
      if (!busy && !done) begin
        if (issued < 3) begin
          op = T_ADD; a = va[issued]; b = vb[issued]; cf_in = 1'b0; start = 1'b1;
          exp_q.push_back(ve[issued]);
          issued++;
        end else begin
          start = 1'b0;
          stop = 1;
        end
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        op = 3'($urandom_range(0, 7));
        cf_in = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    period_chk = 0;
    chk("held_start_issued", 16'(issued), 16'd3);

    // Abort during HI; start asserted under reset must be ignored
    wait_idle();
    op = T_SBC; a = 8'h80; b = 8'h01; cf_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_in_hi", 16'(state_dbg), 16'd2);
    nreset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_busy_done", 16'({busy, done}), 16'd0);
    chk("abort_result", 16'(result), 16'h00);
    chk("abort_flags", 16'({cf, hf, vf, zf, sf}), 16'd0);
    @(negedge clk);
    chk("start_in_reset", 16'(state_dbg), 16'd0);
    nreset = 1'b1;
    start = 1'b0;
    done_seen = 0;
    repeat (8) @(negedge clk);
    chk("no_done_after_abort", 16'(done_seen), 16'd0);
    chk("abort_result_hold", 16'(result), 16'h00);

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
